// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared encodings for the cpu32 load/store/writeback stage.
//   - operation encodings (OP_*), access size encodings (SZ_*)
//   - state_t: stage state machine states
//   - is_misaligned(): half/word alignment test on the low lane bits
package mem_stage_pkg;

   localparam logic [1:0] OP_ALU   = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      StIdle,
      StBus,
      StWb
   } state_t;

   // Size 2'b11 is treated as a word access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane_lo);
      logic r;
      r = 1'b0;
      if (size == SZ_HALF) r = lane_lo[0];
      else if (size[1])    r = |lane_lo;
      return r;
   endfunction

endpackage

// File: rtl/mem_stage_lane_align.sv
// mem_stage_lane_align: combinational lane logic for mem_stage.
//   Parameters: DW  data/bus width (power of two, >= 32)
//   Inputs : i_size   access size (SZ_*), i_lane byte lane within the bus word
//            i_signed sign-extend load data
//            i_wdata  store data (low bits used), i_rdata raw bus read data
//   Outputs: o_be     byte enables
//            o_wdata  store data replicated across all lanes
//            o_rdata  addressed load data shifted to bit 0 and extended
module mem_stage_lane_align
   import mem_stage_pkg::*;
#(
   parameter int unsigned DW = 32,
   localparam int unsigned NB = DW / 8,
   localparam int unsigned LW = $clog2(NB)
) (
   input  logic [1:0]    i_size,
   input  logic [LW-1:0] i_lane,
   input  logic          i_signed,
   input  logic [DW-1:0] i_wdata,
   input  logic [DW-1:0] i_rdata,
   output logic [NB-1:0] o_be,
   output logic [DW-1:0] o_wdata,
   output logic [DW-1:0] o_rdata
);

   logic [LW-1:0] w_lane_eff;
   logic [DW-1:0] w_mask;
   logic [DW-1:0] w_shifted;
   logic          w_sign;

   assign w_shifted = i_rdata >> {w_lane_eff, 3'b000};

   always_comb begin
      w_lane_eff = i_lane;
      o_be       = '0;
      o_wdata    = '0;
      w_mask     = '0;
      w_sign     = 1'b0;
      case (i_size)
         SZ_BYTE: begin
            w_lane_eff = i_lane;
            o_be       = NB'(1) << i_lane;
            o_wdata    = {NB{i_wdata[7:0]}};
            w_mask     = DW'(8'hFF);
            w_sign     = w_shifted[7];
         end
         SZ_HALF: begin
            w_lane_eff = i_lane & ~LW'(1);
            o_be       = NB'(2'b11) << w_lane_eff;
            o_wdata    = {(DW/16){i_wdata[15:0]}};
            w_mask     = DW'(16'hFFFF);
            w_sign     = w_shifted[15];
         end
         default: begin
            w_lane_eff = i_lane & ~LW'(3);
            o_be       = NB'(4'hF) << w_lane_eff;
            o_wdata    = {(DW/32){i_wdata[31:0]}};
            w_mask     = DW'(32'hFFFF_FFFF);
            w_sign     = w_shifted[31];
         end
      endcase
      // For a full-width word ~w_mask is zero, so no extension happens.
      o_rdata = (w_shifted & w_mask) | ((i_signed & w_sign) ? ~w_mask : '0);
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store and writeback stage of the cpu32 pipeline.
//   Optional feature macro: MEM_STAGE_MISALIGN_TRAP_EN (adds fault/fault_addr ports and
//   turns misaligned half/word accesses into a bus-less faulting retire).
//   Ports:
//     clk, reset (async active-low)
//     in_*      operation input, valid/ready handshake (in_ready only in IDLE)
//     d_*       data bus request/acknowledge; request outputs are registered
//     out_*     registered writeback result, out_valid pulses for one cycle
//     q_sela/b  decode-stage source selects, hazard = pending write to one of them
//     fault, fault_addr (macro only) misaligned access report
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned DW        = 32,
   parameter int unsigned AW        = 32,
   parameter int unsigned RSW       = 4,
   parameter int unsigned NOHAZ_REG = 15
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_op,
   input  logic [1:0]      in_size,
   input  logic            in_signed,
   input  logic [AW-1:0]   in_addr,
   input  logic [DW-1:0]   in_wdata,
   input  logic            in_regs_we,
   input  logic [RSW-1:0]  in_wsel,
   output logic            d_req,
   output logic            d_we,
   output logic [AW-1:0]   d_addr,
   output logic [DW-1:0]   d_wdata,
   output logic [DW/8-1:0] d_be,
   input  logic            d_ack,
   input  logic [DW-1:0]   d_rdata,
   output logic            out_valid,
   output logic            out_we,
   output logic [RSW-1:0]  out_wsel,
   output logic [DW-1:0]   out_data,
   input  logic [RSW-1:0]  q_sela,
   input  logic [RSW-1:0]  q_selb,
   output logic            hazard
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   ,
   output logic            fault,
   output logic [AW-1:0]   fault_addr
`endif
);

   localparam int unsigned NB = DW / 8;
   localparam int unsigned LW = $clog2(NB);

   state_t          r_state;
   logic [1:0]      r_size;
   logic [LW-1:0]   r_lane;
   logic            r_signed;
   logic            r_is_load;
   logic            r_regs_we;
   logic [RSW-1:0]  r_wsel;
   logic            r_req;
   logic            r_we;
   logic [AW-1:0]   r_addr;
   logic [DW-1:0]   r_wdata;
   logic [NB-1:0]   r_be;
   logic            r_valid;
   logic            r_out_we;
   logic [DW-1:0]   r_data;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   logic            r_fault;
   logic [AW-1:0]   r_fault_addr;
   logic            w_misalign;
`endif

   logic [LW-1:0]   w_lane;
   logic            w_is_mem;
   logic [1:0]      w_al_size;
   logic [LW-1:0]   w_al_lane;
   logic [NB-1:0]   w_be;
   logic [DW-1:0]   w_st_data;
   logic [DW-1:0]   w_ld_data;
   logic            w_pending;

   assign w_lane   = in_addr[LW-1:0];
   assign w_is_mem = (in_op == OP_LOAD) || (in_op == OP_STORE);

   // One lane_align serves both phases: IDLE uses the incoming op to build the
   // request, BUS uses the latched op to extract the returning read data.
   assign w_al_size = (r_state == StIdle) ? in_size : r_size;
   assign w_al_lane = (r_state == StIdle) ? w_lane  : r_lane;

   mem_stage_lane_align #(
      .DW (DW)
   ) u_lane_align (
      .i_size   (w_al_size),
      .i_lane   (w_al_lane),
      .i_signed (r_signed),
      .i_wdata  (in_wdata),
      .i_rdata  (d_rdata),
      .o_be     (w_be),
      .o_wdata  (w_st_data),
      .o_rdata  (w_ld_data)
   );

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   assign w_misalign = w_is_mem & is_misaligned(in_size, w_lane[1:0]);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= StIdle;
         r_size       <= '0;
         r_lane       <= '0;
         r_signed     <= 1'b0;
         r_is_load    <= 1'b0;
         r_regs_we    <= 1'b0;
         r_wsel       <= '0;
         r_req        <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_be         <= '0;
         r_valid      <= 1'b0;
         r_out_we     <= 1'b0;
         r_data       <= '0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
         r_fault      <= 1'b0;
         r_fault_addr <= '0;
`endif
      end else begin
         case (r_state)
            StIdle: begin
               if (in_valid) begin
                  r_size    <= in_size;
                  r_lane    <= w_lane;
                  r_signed  <= in_signed;
                  r_is_load <= (in_op == OP_LOAD);
                  r_regs_we <= in_regs_we;
                  r_wsel    <= in_wsel;
                  if (!w_is_mem) begin
                     // ALU pass (and reserved op): result is the ALU value itself.
                     r_state  <= StWb;
                     r_valid  <= 1'b1;
                     r_out_we <= in_regs_we;
                     r_data   <= in_addr;
                  end
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                  else if (w_misalign) begin
                     r_state      <= StWb;
                     r_valid      <= 1'b1;
                     r_out_we     <= 1'b0;
                     r_fault      <= 1'b1;
                     r_fault_addr <= in_addr;
                  end
`endif
                  else begin
                     r_state <= StBus;
                     r_req   <= 1'b1;
                     r_we    <= (in_op == OP_STORE);
                     r_addr  <= {in_addr[AW-1:LW], LW'(0)};
                     r_wdata <= w_st_data;
                     r_be    <= w_be;
                  end
               end
            end
            StBus: begin
               if (d_ack) begin
                  r_state  <= StWb;
                  r_req    <= 1'b0;
                  r_valid  <= 1'b1;
                  r_out_we <= r_is_load & r_regs_we;
                  if (r_is_load) r_data <= w_ld_data;
               end
            end
            StWb: begin
               r_state  <= StIdle;
               r_valid  <= 1'b0;
               r_out_we <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
               r_fault  <= 1'b0;
`endif
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign w_pending = (r_state != StIdle) && r_regs_we && (r_wsel != RSW'(NOHAZ_REG));
   assign hazard    = w_pending && ((r_wsel == q_sela) || (r_wsel == q_selb));

   assign in_ready  = (r_state == StIdle);
   assign d_req     = r_req;
   assign d_we      = r_we;
   assign d_addr    = r_addr;
   assign d_wdata   = r_wdata;
   assign d_be      = r_be;
   assign out_valid = r_valid;
   assign out_we    = r_out_we;
   assign out_wsel  = r_wsel;
   assign out_data  = r_data;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   assign fault      = r_fault;
   assign fault_addr = r_fault_addr;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage (DW=32, AW=32, RSW=4).
//   Exercises reset, ALU pass, stores, loads with extension, hazards, mid-transaction
//   reset, misaligned handling (either MEM_STAGE_MISALIGN_TRAP_EN setting) and
//   back-to-back ALU throughput.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [1:0]  in_size;
   logic        in_signed;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic        in_regs_we;
   logic [3:0]  in_wsel;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        out_valid;
   logic        out_we;
   logic [3:0]  out_wsel;
   logic [31:0] out_data;
   logic [3:0]  q_sela;
   logic [3:0]  q_selb;
   logic        hazard;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   logic        fault;
   logic [31:0] fault_addr;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   mem_stage #(
      .DW        (32),
      .AW        (32),
      .RSW       (4),
      .NOHAZ_REG (15)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_size    (in_size),
      .in_signed  (in_signed),
      .in_addr    (in_addr),
      .in_wdata   (in_wdata),
      .in_regs_we (in_regs_we),
      .in_wsel    (in_wsel),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_be       (d_be),
      .d_ack      (d_ack),
      .d_rdata    (d_rdata),
      .out_valid  (out_valid),
      .out_we     (out_we),
      .out_wsel   (out_wsel),
      .out_data   (out_data),
      .q_sela     (q_sela),
      .q_selb     (q_selb),
      .hazard     (hazard)
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      ,
      .fault      (fault),
      .fault_addr (fault_addr)
`endif
   );

   always #5 clk = ~clk;

   // Load table: addr, size, signed, bus read data, expected be, expected result.
   localparam logic [31:0] LD_ADDR [6] = '{32'h101, 32'h101, 32'h102, 32'h100, 32'h104, 32'h107};
   localparam logic [1:0]  LD_SIZE [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
   localparam logic        LD_SGN  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
   localparam logic [31:0] LD_RD   [6] = '{32'h0000_8000, 32'h0000_8000, 32'h8001_0000,
                                           32'h1234_ABCD, 32'hDEAD_BEEF, 32'h7F00_0000};
   localparam logic [3:0]  LD_BE   [6] = '{4'b0010, 4'b0010, 4'b1100, 4'b0011, 4'b1111, 4'b1000};
   localparam logic [31:0] LD_EXP  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001,
                                           32'h0000_ABCD, 32'hDEAD_BEEF, 32'h0000_007F};

   // Store table: addr, size, wdata, expected be, expected bus data.
   localparam logic [31:0] ST_ADDR [3] = '{32'h102, 32'h108, 32'h10C};
   localparam logic [1:0]  ST_SIZE [3] = '{2'b01, 2'b10, 2'b11};
   localparam logic [31:0] ST_WD   [3] = '{32'h1234_5678, 32'hCAFE_F00D, 32'h0102_0304};
   localparam logic [3:0]  ST_BE   [3] = '{4'b1100, 4'b1111, 4'b1111};
   localparam logic [31:0] ST_EXP  [3] = '{32'h5678_5678, 32'hCAFE_F00D, 32'h0102_0304};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd, input logic we,
                        input logic [3:0] wsel);
      in_valid   = 1'b1;
      in_op      = op;
      in_size    = size;
      in_signed  = sgn;
      in_addr    = addr;
      in_wdata   = wd;
      in_regs_we = we;
      in_wsel    = wsel;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      in_valid = 1'b0; in_op = 2'b00; in_size = 2'b00; in_signed = 1'b0;
      in_addr = '0; in_wdata = '0; in_regs_we = 1'b0; in_wsel = '0;
      d_ack = 1'b0; d_rdata = '0; q_sela = '0; q_selb = '0;
      step();
      step();
      n_checks++;
      if ({in_ready, d_req, d_we, out_valid, out_we, hazard} !== 6'b100000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 100000",
                  {in_ready, d_req, d_we, out_valid, out_we, hazard});
      end
      n_checks++;
      if ({d_be, d_addr, d_wdata, out_wsel, out_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: be=%h addr=%h wd=%h wsel=%h data=%h want all 0",
                  d_be, d_addr, d_wdata, out_wsel, out_data);
      end
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      n_checks++;
      if ({fault, fault_addr} !== 33'h0) begin
         n_fail++;
         $display("FAIL reset_fault: got %b/%h want 0/0", fault, fault_addr);
      end
`endif
      @(negedge clk);
      reset = 1'b1;
      step();
   endtask

   task automatic test_alu();
      offer(2'b00, 2'b00, 1'b0, 32'h1234, 32'h0, 1'b1, 4'd3);
      step();
      in_valid = 1'b0;
      n_checks++;
      if ({in_ready, out_valid, out_we, out_wsel} !== {3'b011, 4'd3}) begin
         n_fail++;
         $display("FAIL alu_wb_ctrl: ready/valid/we/wsel=%b%b%b/%0d want 011/3",
                  in_ready, out_valid, out_we, out_wsel);
      end
      n_checks++;
      if (out_data !== 32'h1234) begin
         n_fail++;
         $display("FAIL alu_wb_data: got %h want 00001234", out_data);
      end
      step();
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL alu_retire: valid/ready=%b%b want 01", out_valid, in_ready);
      end
   endtask

   task automatic test_store_byte();
      offer(2'b10, 2'b00, 1'b0, 32'h103, 32'hAB, 1'b0, 4'd0);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (d_req !== 1'b1) begin
            n_fail++;
            $display("FAIL stb_req_cycle%0d: got %b want 1", i, d_req);
         end
         if (i == 0 || i == 3) begin
            n_checks++;
            if ({d_we, d_be, d_addr, d_wdata} !== {1'b1, 4'b1000, 32'h100, 32'hABAB_ABAB}) begin
               n_fail++;
               $display("FAIL stb_bus_cycle%0d: we=%b be=%b addr=%h wd=%h want 1 1000 100 abababab",
                        i, d_we, d_be, d_addr, d_wdata);
            end
         end
         d_ack = (i == 3);
         step();
      end
      d_ack = 1'b0;
      n_checks++;
      if ({d_req, out_valid, out_we} !== 3'b010) begin
         n_fail++;
         $display("FAIL stb_retire: req/valid/we=%b%b%b want 010", d_req, out_valid, out_we);
      end
      step();
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL stb_idle: valid/ready=%b%b want 01", out_valid, in_ready);
      end
   endtask

   task automatic test_store_lanes();
      for (int i = 0; i < 3; i++) begin
         offer(2'b10, ST_SIZE[i], 1'b0, ST_ADDR[i], ST_WD[i], 1'b0, 4'd1);
         step();
         in_valid = 1'b0;
         n_checks++;
         if ({d_req, d_we, d_be, d_addr, d_wdata} !==
             {2'b11, ST_BE[i], ST_ADDR[i] & ~32'h3, ST_EXP[i]}) begin
            n_fail++;
            $display("FAIL st_lane%0d: req=%b we=%b be=%b addr=%h wd=%h want 1 1 %b %h %h", i,
                     d_req, d_we, d_be, d_addr, d_wdata, ST_BE[i], ST_ADDR[i] & ~32'h3,
                     ST_EXP[i]);
         end
         d_ack = 1'b1;
         step();
         d_ack = 1'b0;
         n_checks++;
         if ({out_valid, out_we} !== 2'b10) begin
            n_fail++;
            $display("FAIL st_retire%0d: valid/we=%b%b want 10", i, out_valid, out_we);
         end
         step();
      end
   endtask

   task automatic test_loads();
      for (int i = 0; i < 6; i++) begin
         offer(2'b01, LD_SIZE[i], LD_SGN[i], LD_ADDR[i], 32'h0, 1'b1, 4'(4 + i));
         step();
         in_valid = 1'b0;
         n_checks++;
         if ({d_req, d_we, d_be, d_addr} !== {2'b10, LD_BE[i], LD_ADDR[i] & ~32'h3}) begin
            n_fail++;
            $display("FAIL ld_req%0d: req=%b we=%b be=%b addr=%h want 1 0 %b %h", i, d_req, d_we,
                     d_be, d_addr, LD_BE[i], LD_ADDR[i] & ~32'h3);
         end
         d_ack   = 1'b1;
         d_rdata = LD_RD[i];
         step();
         d_ack   = 1'b0;
         d_rdata = 32'h0;
         n_checks++;
         if ({out_valid, out_we, out_wsel, out_data} !== {2'b11, 4'(4 + i), LD_EXP[i]}) begin
            n_fail++;
            $display("FAIL ld_data%0d: valid=%b we=%b wsel=%0d data=%h want 1 1 %0d %h", i,
                     out_valid, out_we, out_wsel, out_data, 4 + i, LD_EXP[i]);
         end
         step();
      end
   endtask

   task automatic test_hazard();
      q_sela = 4'd5;
      q_selb = 4'd0;
      offer(2'b01, 2'b10, 1'b0, 32'h200, 32'h0, 1'b1, 4'd5);
      #1;
      n_checks++;
      if (hazard !== 1'b0) begin
         n_fail++;
         $display("FAIL haz_idle: got %b want 0", hazard);
      end
      step();
      in_valid = 1'b0;
      n_checks++;
      if (hazard !== 1'b1) begin
         n_fail++;
         $display("FAIL haz_bus_a: got %b want 1", hazard);
      end
      q_sela = 4'd0; q_selb = 4'd5;
      #1;
      n_checks++;
      if (hazard !== 1'b1) begin
         n_fail++;
         $display("FAIL haz_bus_b: got %b want 1", hazard);
      end
      q_sela = 4'd6; q_selb = 4'd7;
      #1;
      n_checks++;
      if (hazard !== 1'b0) begin
         n_fail++;
         $display("FAIL haz_nomatch: got %b want 0", hazard);
      end
      q_sela = 4'd5;
      d_ack  = 1'b1;
      step();
      d_ack  = 1'b0;
      n_checks++;
      if ({out_valid, hazard} !== 2'b11) begin
         n_fail++;
         $display("FAIL haz_wb: valid/hazard=%b%b want 11", out_valid, hazard);
      end
      step();
      n_checks++;
      if (hazard !== 1'b0) begin
         n_fail++;
         $display("FAIL haz_cleared: got %b want 0", hazard);
      end
      // NOHAZ_REG destination never reports.
      q_sela = 4'd15;
      offer(2'b01, 2'b10, 1'b0, 32'h204, 32'h0, 1'b1, 4'd15);
      step();
      in_valid = 1'b0;
      n_checks++;
      if ({d_req, hazard} !== 2'b10) begin
         n_fail++;
         $display("FAIL haz_noreg: req/hazard=%b%b want 10", d_req, hazard);
      end
      d_ack = 1'b1;
      step();
      d_ack = 1'b0;
      step();
      // Operation without register write never reports.
      q_sela = 4'd5;
      offer(2'b10, 2'b10, 1'b0, 32'h208, 32'h0, 1'b0, 4'd5);
      step();
      in_valid = 1'b0;
      n_checks++;
      if ({d_req, hazard} !== 2'b10) begin
         n_fail++;
         $display("FAIL haz_nowe: req/hazard=%b%b want 10", d_req, hazard);
      end
      d_ack = 1'b1;
      step();
      d_ack = 1'b0;
      step();
      q_sela = 4'd0;
      q_selb = 4'd0;
   endtask

   task automatic test_reset_mid();
      offer(2'b01, 2'b10, 1'b0, 32'h300, 32'h0, 1'b1, 4'd9);
      step();
      in_valid = 1'b0;
      n_checks++;
      if (d_req !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_req: got %b want 1", d_req);
      end
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({d_req, in_ready, out_valid} !== 3'b010) begin
         n_fail++;
         $display("FAIL rstmid_async: req/ready/valid=%b%b%b want 010", d_req, in_ready,
                  out_valid);
      end
      @(negedge clk);
      reset = 1'b1;
      step();
      offer(2'b00, 2'b00, 1'b0, 32'h55, 32'h0, 1'b1, 4'd2);
      step();
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid, out_we, out_wsel, out_data} !== {2'b11, 4'd2, 32'h55}) begin
         n_fail++;
         $display("FAIL rstmid_alu: valid=%b we=%b wsel=%0d data=%h want 1 1 2 00000055",
                  out_valid, out_we, out_wsel, out_data);
      end
      step();
   endtask

   task automatic test_misalign();
      offer(2'b01, 2'b10, 1'b0, 32'h102, 32'h0, 1'b1, 4'd7);
      step();
      in_valid = 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      n_checks++;
      if ({d_req, out_valid, out_we, fault} !== 4'b0101) begin
         n_fail++;
         $display("FAIL mis_trap: req/valid/we/fault=%b%b%b%b want 0101", d_req, out_valid,
                  out_we, fault);
      end
      n_checks++;
      if (fault_addr !== 32'h102) begin
         n_fail++;
         $display("FAIL mis_addr: got %h want 00000102", fault_addr);
      end
      step();
      n_checks++;
      if ({fault, in_ready, d_req} !== 3'b010) begin
         n_fail++;
         $display("FAIL mis_after: fault/ready/req=%b%b%b want 010", fault, in_ready, d_req);
      end
`else
      n_checks++;
      if ({d_req, d_be, d_addr} !== {1'b1, 4'hF, 32'h100}) begin
         n_fail++;
         $display("FAIL mis_align: req=%b be=%h addr=%h want 1 f 00000100", d_req, d_be,
                  d_addr);
      end
      d_ack   = 1'b1;
      d_rdata = 32'h1122_3344;
      step();
      d_ack   = 1'b0;
      n_checks++;
      if ({out_valid, out_we, out_data} !== {2'b11, 32'h1122_3344}) begin
         n_fail++;
         $display("FAIL mis_data: valid=%b we=%b data=%h want 1 1 11223344", out_valid, out_we,
                  out_data);
      end
      step();
`endif
   endtask

   task automatic test_back_to_back();
      // Stray ack while idle must do nothing.
      d_ack = 1'b1;
      step();
      d_ack = 1'b0;
      n_checks++;
      if ({in_ready, out_valid, d_req} !== 3'b100) begin
         n_fail++;
         $display("FAIL ack_idle: ready/valid/req=%b%b%b want 100", in_ready, out_valid, d_req);
      end
      offer(2'b11, 2'b00, 1'b0, 32'h1, 32'h0, 1'b1, 4'd1);
      step();
      in_addr = 32'h2;
      in_wsel = 4'd2;
      n_checks++;
      if ({out_valid, in_ready, out_data} !== {2'b10, 32'h1}) begin
         n_fail++;
         $display("FAIL b2b_first: valid=%b ready=%b data=%h want 1 0 00000001", out_valid,
                  in_ready, out_data);
      end
      step();
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL b2b_gap: valid/ready=%b%b want 01", out_valid, in_ready);
      end
      step();
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid, out_wsel, out_data} !== {1'b1, 4'd2, 32'h2}) begin
         n_fail++;
         $display("FAIL b2b_second: valid=%b wsel=%0d data=%h want 1 2 00000002", out_valid,
                  out_wsel, out_data);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_store_byte();
      test_store_lanes();
      test_loads();
      test_hazard();
      test_reset_mid();
      test_misalign();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
